// File: rtl/csr_irq_file.sv
// Machine-mode CSR file and trap controller for the RV32IM 5-stage core.
// Takes trap events and the PC of the instruction raising them at the EX/MEM
// boundary, applies exactly one event per cycle (illegal > ebreak > ecall >
// irq > mret > CSR write), and returns a registered redirect pulse.
//
// Handshake: there is no back-pressure. An event or CSR access is valid for
// exactly the cycle it is presented. Its effect lands on the next rising edge,
// and the trap/mret pulses are high for the one cycle after that edge.
module csr_irq_file #(
  parameter int          XLEN        = 32,
  parameter int          NUM_IRQ     = 4,
  parameter logic [31:0] RESET_MTVEC = 32'h28
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [XLEN-1:0]    pc_i,
  input  logic               retire_i,
  input  logic               is_illegal_i,
  input  logic               is_ebreak_i,
  input  logic               is_ecall_i,
  input  logic               is_mret_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               csr_en_i,
  input  logic [1:0]         csr_op_i,
  input  logic [11:0]        csr_addr_i,
  input  logic [XLEN-1:0]    csr_wdata_i,
  output logic [XLEN-1:0]    csr_rdata_o,
  output logic               csr_illegal_o,
  output logic               trap_taken_o,
  output logic               irq_taken_o,
  output logic [XLEN-1:0]    trap_target_o,
  output logic               mret_taken_o,
  output logic [XLEN-1:0]    mepc_o
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MHARTID  = 12'hF14;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTR   = 12'hB02;
  localparam logic [11:0] A_MINSTRH  = 12'hB82;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  // Architectural state
  logic               mstatus_mie_q, mstatus_mie_d;
  logic               mstatus_mpie_q, mstatus_mpie_d;
  logic [NUM_IRQ-1:0] mie_q, mie_d;
  logic [31:0]        mtvec_q, mtvec_d;
  logic [31:0]        mscratch_q, mscratch_d;
  logic [31:0]        mepc_q, mepc_d;
  logic [31:0]        mcause_q, mcause_d;
  logic [63:0]        mcycle_q, mcycle_d;
  logic [63:0]        minstret_q, minstret_d;

  // Registered redirect outputs
  logic               trap_taken_q, trap_taken_d;
  logic               irq_taken_q, irq_taken_d;
  logic               mret_taken_q, mret_taken_d;
  logic [31:0]        trap_target_q, trap_target_d;

  // Decode / event signals
  logic               addr_known;
  logic               addr_ro;
  logic [31:0]        rdata;
  logic [31:0]        wval;
  logic               csr_wr_req;
  logic [NUM_IRQ-1:0] irq_pend;
  logic               irq_any;
  logic [3:0]         irq_idx;
  logic [4:0]         irq_cause;
  logic               take_exc;
  logic               take_irq;
  logic               take_mret;
  logic               take_csr;
  logic [31:0]        tvec_base;

  // Read mux: returns the pre-write value of the addressed CSR
  always_comb begin
    rdata      = 32'h0;
    addr_known = 1'b1;
    case (csr_addr_i)
      A_MSTATUS: begin
        rdata[12:11] = 2'b11;
        rdata[7]     = mstatus_mpie_q;
        rdata[3]     = mstatus_mie_q;
      end
      A_MIE:      rdata[16 +: NUM_IRQ] = mie_q;
      A_MTVEC:    rdata = mtvec_q;
      A_MSCRATCH: rdata = mscratch_q;
      A_MEPC:     rdata = mepc_q;
      A_MCAUSE:   rdata = mcause_q;
      A_MIP:      rdata[16 +: NUM_IRQ] = irq_i;
      A_MHARTID:  rdata = 32'h0;
      A_MCYCLE:   rdata = mcycle_q[31:0];
      A_MCYCLEH:  rdata = mcycle_q[63:32];
      A_MINSTR:   rdata = minstret_q[31:0];
      A_MINSTRH:  rdata = minstret_q[63:32];
      default:    addr_known = 1'b0;
    endcase
  end

  assign addr_ro       = (csr_addr_i == A_MIP) || (csr_addr_i == A_MHARTID);
  assign csr_illegal_o = csr_en_i && (!addr_known || ((csr_op_i != 2'b00) && addr_ro));
  assign csr_rdata_o   = rdata;

  // Write-value computation for RW / RS / RC
  always_comb begin
    case (csr_op_i)
      OP_RW:   wval = csr_wdata_i;
      OP_RS:   wval = rdata | csr_wdata_i;
      OP_RC:   wval = rdata & ~csr_wdata_i;
      default: wval = rdata;
    endcase
  end

  // RS/RC with a zero operand is a pure read and must not write
  assign csr_wr_req = csr_en_i && !csr_illegal_o &&
                      ((csr_op_i == OP_RW) || (csr_op_i[1] && (csr_wdata_i != 32'h0)));

  // Interrupt selection: the lowest-numbered enabled, pending line wins
  assign irq_pend = irq_i & mie_q & {NUM_IRQ{mstatus_mie_q}};
  assign irq_any  = |irq_pend;

  always_comb begin
    irq_idx = 4'd0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (irq_pend[k]) irq_idx = 4'(k);
    end
  end

  assign irq_cause = 5'd16 + {1'b0, irq_idx};

  // One event per cycle, in fixed priority order
  assign take_exc  = is_illegal_i || is_ebreak_i || is_ecall_i;
  assign take_irq  = !take_exc && irq_any;
  assign take_mret = !take_exc && !irq_any && is_mret_i;
  assign take_csr  = !take_exc && !irq_any && !is_mret_i && csr_wr_req;

  assign tvec_base = {mtvec_q[31:2], 2'b00};

  // Next-state logic: counters, trap entry/exit and CSR writes
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mcycle_d       = mcycle_q + 64'd1;
    minstret_d     = minstret_q + {63'd0, retire_i};
    trap_taken_d   = 1'b0;
    irq_taken_d    = 1'b0;
    mret_taken_d   = 1'b0;
    trap_target_d  = trap_target_q;

    if (take_exc) begin
      mepc_d         = {pc_i[31:2], 2'b00};
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      if (is_illegal_i)     mcause_d = 32'd2;
      else if (is_ebreak_i) mcause_d = 32'd3;
      else                  mcause_d = 32'd11;
      trap_taken_d   = 1'b1;
      trap_target_d  = tvec_base;
    end else if (take_irq) begin
      mepc_d         = {pc_i[31:2], 2'b00};
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      mcause_d       = {1'b1, 26'd0, irq_cause};
      trap_taken_d   = 1'b1;
      irq_taken_d    = 1'b1;
      trap_target_d  = (mtvec_q[1:0] == 2'b01) ?
                       (tvec_base + {25'd0, irq_cause, 2'b00}) : tvec_base;
    end else if (take_mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
      mret_taken_d   = 1'b1;
    end else if (take_csr) begin
      case (csr_addr_i)
        A_MSTATUS: begin
          mstatus_mie_d  = wval[3];
          mstatus_mpie_d = wval[7];
        end
        A_MIE:      mie_d      = wval[16 +: NUM_IRQ];
        // Reserved MODE encodings 2 and 3 fall back to direct mode
        A_MTVEC:    mtvec_d    = {wval[31:2], (wval[1] ? 2'b00 : wval[1:0])};
        A_MSCRATCH: mscratch_d = wval;
        A_MEPC:     mepc_d     = {wval[31:2], 2'b00};
        A_MCAUSE:   mcause_d   = wval;
        A_MCYCLE:   mcycle_d   = {mcycle_q[63:32], wval};
        A_MCYCLEH:  mcycle_d   = {wval, mcycle_q[31:0]};
        A_MINSTR:   minstret_d = {minstret_q[63:32], wval};
        A_MINSTRH:  minstret_d = {wval, minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= RESET_MTVEC;
      mscratch_q     <= 32'h0;
      mepc_q         <= 32'h0;
      mcause_q       <= 32'h0;
      mcycle_q       <= 64'h0;
      minstret_q     <= 64'h0;
      trap_taken_q   <= 1'b0;
      irq_taken_q    <= 1'b0;
      mret_taken_q   <= 1'b0;
      trap_target_q  <= 32'h0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
      trap_taken_q   <= trap_taken_d;
      irq_taken_q    <= irq_taken_d;
      mret_taken_q   <= mret_taken_d;
      trap_target_q  <= trap_target_d;
    end
  end

  // Reset also masks an in-flight pulse so a trap launched in the cycle
  // before reset is never acted on by the pipeline.
  assign trap_taken_o  = trap_taken_q && !rst;
  assign irq_taken_o   = irq_taken_q && !rst;
  assign mret_taken_o  = mret_taken_q && !rst;
  assign trap_target_o = trap_target_q;
  assign mepc_o        = mepc_q;

endmodule

// File: tb/tb_csr_irq_file.sv
// Self-checking bench for csr_irq_file: reset values, vectored interrupts,
// exceptions and mret, event priority, CSR op semantics, counters, and
// reset arriving while a trap pulse is in flight.
module tb_csr_irq_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        retire_i;
  logic        is_illegal_i, is_ebreak_i, is_ecall_i, is_mret_i;
  logic [3:0]  irq_i;
  logic        csr_en_i;
  logic [1:0]  csr_op_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;
  logic        csr_illegal_o;
  logic        trap_taken_o, irq_taken_o, mret_taken_o;
  logic [31:0] trap_target_o;
  logic [31:0] mepc_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Expected redirect outcome: {trap, irq, mret, target}
  logic [34:0] exp_q[$];
  logic [34:0] exp_v;
  logic [31:0] rd_v;
  logic        ill_v;

  csr_irq_file #(.XLEN(32), .NUM_IRQ(4), .RESET_MTVEC(32'h28)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .retire_i(retire_i),
    .is_illegal_i(is_illegal_i), .is_ebreak_i(is_ebreak_i),
    .is_ecall_i(is_ecall_i), .is_mret_i(is_mret_i), .irq_i(irq_i),
    .csr_en_i(csr_en_i), .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i),
    .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o),
    .csr_illegal_o(csr_illegal_o), .trap_taken_o(trap_taken_o),
    .irq_taken_o(irq_taken_o), .trap_target_o(trap_target_o),
    .mret_taken_o(mret_taken_o), .mepc_o(mepc_o)
  );

  // Clock and watchdog
  always #10 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    retire_i = 1'b0; is_illegal_i = 1'b0; is_ebreak_i = 1'b0;
    is_ecall_i = 1'b0; is_mret_i = 1'b0; irq_i = 4'b0;
    csr_en_i = 1'b0; csr_op_i = 2'b00; csr_addr_i = 12'h0; csr_wdata_i = 32'h0;
  endtask

  task automatic csr_read(input logic [11:0] a, output logic [31:0] d, output logic ill);
    csr_en_i = 1'b1; csr_op_i = 2'b00; csr_addr_i = a; csr_wdata_i = 32'h0;
    #1;
    d = csr_rdata_o;
    ill = csr_illegal_o;
    csr_en_i = 1'b0;
  endtask

  task automatic csr_write(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    csr_en_i = 1'b1; csr_op_i = op; csr_addr_i = a; csr_wdata_i = d;
    tick();
    csr_en_i = 1'b0; csr_op_i = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc_i = 32'h0; clear_inputs();
    tick(); tick();
    total_cnt++; if (trap_taken_o !== 1'b0) $display("FAIL rst_trap: got %b exp 0", trap_taken_o); else pass_cnt++;
    total_cnt++; if (trap_target_o !== 32'h0) $display("FAIL rst_target: got %h exp 0", trap_target_o); else pass_cnt++;
    rst = 1'b0;
    csr_read(12'h305, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h28) $display("FAIL rst_mtvec: got %h exp 28", rd_v); else pass_cnt++;
    csr_read(12'h300, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h1800) $display("FAIL rst_mstatus: got %h exp 1800", rd_v); else pass_cnt++;
    csr_read(12'h344, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h0) $display("FAIL rst_mip: got %h exp 0", rd_v); else pass_cnt++;
    total_cnt++; if (ill_v !== 1'b0) $display("FAIL rst_mip_ro_read_legal: got %b exp 0", ill_v); else pass_cnt++;
    csr_read(12'h304, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h0) $display("FAIL rst_mie: got %h exp 0", rd_v); else pass_cnt++;
    total_cnt++; if (mepc_o !== 32'h0) $display("FAIL rst_mepc: got %h exp 0", mepc_o); else pass_cnt++;
    tick();
  endtask

  task automatic test_irq_vectored();
    csr_write(2'b01, 12'h300, 32'h8);
    csr_write(2'b01, 12'h304, 32'h20000);
    csr_write(2'b01, 12'h305, 32'h101);
    csr_read(12'h305, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h101) $display("FAIL irq_mtvec: got %h exp 101", rd_v); else pass_cnt++;
    pc_i = 32'h300; irq_i = 4'b0110;
    exp_q.push_back({3'b110, 32'h144});
    tick();
    exp_v = exp_q.pop_front();
    total_cnt++; if ({trap_taken_o, irq_taken_o, mret_taken_o} !== exp_v[34:32])
      $display("FAIL irq_pulses: got %b exp %b", {trap_taken_o, irq_taken_o, mret_taken_o}, exp_v[34:32]); else pass_cnt++;
    total_cnt++; if (trap_target_o !== exp_v[31:0]) $display("FAIL irq_target: got %h exp %h", trap_target_o, exp_v[31:0]); else pass_cnt++;
    tick();
    total_cnt++; if (trap_taken_o !== 1'b0) $display("FAIL irq_pulse_width: got %b exp 0", trap_taken_o); else pass_cnt++;
    irq_i = 4'b0;
    csr_read(12'h342, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h80000011) $display("FAIL irq_mcause: got %h exp 80000011", rd_v); else pass_cnt++;
    csr_read(12'h300, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h1880) $display("FAIL irq_mstatus: got %h exp 1880", rd_v); else pass_cnt++;
    total_cnt++; if (mepc_o !== 32'h300) $display("FAIL irq_mepc: got %h exp 300", mepc_o); else pass_cnt++;
    tick();
  endtask

  task automatic test_ecall_mret();
    csr_write(2'b01, 12'h300, 32'h8);
    irq_i = 4'b0110; is_ecall_i = 1'b1; pc_i = 32'h200;
    exp_q.push_back({3'b100, 32'h100});
    tick();
    is_ecall_i = 1'b0; irq_i = 4'b0;
    exp_v = exp_q.pop_front();
    total_cnt++; if ({trap_taken_o, irq_taken_o, mret_taken_o} !== exp_v[34:32])
      $display("FAIL ecall_pulses: got %b exp %b", {trap_taken_o, irq_taken_o, mret_taken_o}, exp_v[34:32]); else pass_cnt++;
    total_cnt++; if (trap_target_o !== exp_v[31:0]) $display("FAIL ecall_target: got %h exp %h", trap_target_o, exp_v[31:0]); else pass_cnt++;
    csr_read(12'h342, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'd11) $display("FAIL ecall_mcause: got %h exp b", rd_v); else pass_cnt++;
    total_cnt++; if (mepc_o !== 32'h200) $display("FAIL ecall_mepc: got %h exp 200", mepc_o); else pass_cnt++;
    tick();
    is_mret_i = 1'b1;
    exp_q.push_back({3'b001, 32'h0});
    tick();
    is_mret_i = 1'b0;
    exp_v = exp_q.pop_front();
    total_cnt++; if ({trap_taken_o, irq_taken_o, mret_taken_o} !== exp_v[34:32])
      $display("FAIL mret_pulses: got %b exp %b", {trap_taken_o, irq_taken_o, mret_taken_o}, exp_v[34:32]); else pass_cnt++;
    csr_read(12'h300, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h1888) $display("FAIL mret_mstatus: got %h exp 1888", rd_v); else pass_cnt++;
    tick();
  endtask

  task automatic test_priority();
    // All exceptions, mret and an irq together: illegal wins
    is_illegal_i = 1'b1; is_ebreak_i = 1'b1; is_ecall_i = 1'b1; is_mret_i = 1'b1;
    irq_i = 4'b0010; pc_i = 32'h500;
    exp_q.push_back({3'b100, 32'h100});
    tick();
    clear_inputs();
    exp_v = exp_q.pop_front();
    total_cnt++; if ({trap_taken_o, irq_taken_o, mret_taken_o} !== exp_v[34:32])
      $display("FAIL prio_ill_pulses: got %b exp %b", {trap_taken_o, irq_taken_o, mret_taken_o}, exp_v[34:32]); else pass_cnt++;
    csr_read(12'h342, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'd2) $display("FAIL prio_ill_mcause: got %h exp 2", rd_v); else pass_cnt++;
    is_mret_i = 1'b1; tick(); is_mret_i = 1'b0; tick();
    // ebreak beats ecall
    is_ebreak_i = 1'b1; is_ecall_i = 1'b1;
    tick();
    clear_inputs();
    csr_read(12'h342, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'd3) $display("FAIL prio_ebreak_mcause: got %h exp 3", rd_v); else pass_cnt++;
    is_mret_i = 1'b1; tick(); is_mret_i = 1'b0; tick();
    // irq beats mret and a CSR write; the write is discarded
    irq_i = 4'b0010; is_mret_i = 1'b1; pc_i = 32'h600;
    csr_en_i = 1'b1; csr_op_i = 2'b01; csr_addr_i = 12'h340; csr_wdata_i = 32'h55;
    exp_q.push_back({3'b110, 32'h144});
    tick();
    clear_inputs();
    exp_v = exp_q.pop_front();
    total_cnt++; if ({trap_taken_o, irq_taken_o, mret_taken_o} !== exp_v[34:32])
      $display("FAIL prio_irq_pulses: got %b exp %b", {trap_taken_o, irq_taken_o, mret_taken_o}, exp_v[34:32]); else pass_cnt++;
    total_cnt++; if (trap_target_o !== exp_v[31:0]) $display("FAIL prio_irq_target: got %h exp %h", trap_target_o, exp_v[31:0]); else pass_cnt++;
    csr_read(12'h340, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h0) $display("FAIL prio_irq_csr_dropped: got %h exp 0", rd_v); else pass_cnt++;
    // mret beats a CSR write
    is_mret_i = 1'b1;
    csr_en_i = 1'b1; csr_op_i = 2'b01; csr_addr_i = 12'h340; csr_wdata_i = 32'h77;
    tick();
    clear_inputs();
    total_cnt++; if (mret_taken_o !== 1'b1) $display("FAIL prio_mret_pulse: got %b exp 1", mret_taken_o); else pass_cnt++;
    csr_read(12'h340, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h0) $display("FAIL prio_mret_csr_dropped: got %h exp 0", rd_v); else pass_cnt++;
    csr_read(12'h300, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h1888) $display("FAIL prio_mret_mstatus: got %h exp 1888", rd_v); else pass_cnt++;
    tick();
  endtask

  task automatic test_csr_ops();
    csr_write(2'b11, 12'h300, 32'h8);
    // RS shows the old value and sets bits
    csr_en_i = 1'b1; csr_op_i = 2'b10; csr_addr_i = 12'h304; csr_wdata_i = 32'h10000;
    #1;
    total_cnt++; if (csr_rdata_o !== 32'h20000) $display("FAIL rs_old_value: got %h exp 20000", csr_rdata_o); else pass_cnt++;
    tick(); csr_en_i = 1'b0;
    csr_read(12'h304, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h30000) $display("FAIL rs_result: got %h exp 30000", rd_v); else pass_cnt++;
    csr_write(2'b11, 12'h304, 32'h0);
    csr_read(12'h304, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h30000) $display("FAIL rc_zero_nop: got %h exp 30000", rd_v); else pass_cnt++;
    csr_write(2'b11, 12'h304, 32'h20000);
    csr_read(12'h304, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h10000) $display("FAIL rc_clear: got %h exp 10000", rd_v); else pass_cnt++;
    // Read-only and unknown addresses
    irq_i = 4'b0101;
    csr_en_i = 1'b1; csr_op_i = 2'b01; csr_addr_i = 12'h344; csr_wdata_i = 32'hFFFF;
    #1;
    total_cnt++; if (csr_illegal_o !== 1'b1) $display("FAIL mip_write_illegal: got %b exp 1", csr_illegal_o); else pass_cnt++;
    tick(); csr_en_i = 1'b0;
    csr_read(12'h344, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h50000) $display("FAIL mip_live: got %h exp 50000", rd_v); else pass_cnt++;
    irq_i = 4'b0;
    csr_en_i = 1'b1; csr_op_i = 2'b10; csr_addr_i = 12'hF14; csr_wdata_i = 32'h1;
    #1;
    total_cnt++; if (csr_illegal_o !== 1'b1) $display("FAIL mhartid_write_illegal: got %b exp 1", csr_illegal_o); else pass_cnt++;
    csr_en_i = 1'b0;
    csr_read(12'hF14, rd_v, ill_v);
    total_cnt++; if ({ill_v, rd_v} !== 33'h0) $display("FAIL mhartid_read: got %b/%h exp 0/0", ill_v, rd_v); else pass_cnt++;
    csr_read(12'h123, rd_v, ill_v);
    total_cnt++; if (ill_v !== 1'b1) $display("FAIL unknown_addr_illegal: got %b exp 1", ill_v); else pass_cnt++;
    tick();
    // Writable fields and masking
    csr_write(2'b01, 12'h340, 32'hDEADBEEF);
    csr_read(12'h340, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'hDEADBEEF) $display("FAIL mscratch_rw: got %h exp deadbeef", rd_v); else pass_cnt++;
    csr_write(2'b01, 12'h341, 32'h203);
    csr_read(12'h341, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h200) $display("FAIL mepc_mask: got %h exp 200", rd_v); else pass_cnt++;
    csr_write(2'b01, 12'h305, 32'h102);
    csr_read(12'h305, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h100) $display("FAIL mtvec_mode2: got %h exp 100", rd_v); else pass_cnt++;
    csr_write(2'b01, 12'h305, 32'h103);
    csr_read(12'h305, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h100) $display("FAIL mtvec_mode3: got %h exp 100", rd_v); else pass_cnt++;
    csr_write(2'b01, 12'h304, 32'hFFFFFFFF);
    csr_read(12'h304, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'hF0000) $display("FAIL mie_mask: got %h exp f0000", rd_v); else pass_cnt++;
    csr_write(2'b01, 12'h300, 32'hFFFFFFFF);
    csr_read(12'h300, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h1888) $display("FAIL mstatus_mask: got %h exp 1888", rd_v); else pass_cnt++;
    csr_write(2'b01, 12'h300, 32'h0);
    csr_write(2'b01, 12'h342, 32'h12345678);
    csr_read(12'h342, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h12345678) $display("FAIL mcause_rw: got %h exp 12345678", rd_v); else pass_cnt++;
  endtask

  task automatic test_counters();
    csr_write(2'b01, 12'hB00, 32'hFFFFFFFF);
    csr_write(2'b01, 12'hB80, 32'h0);
    csr_read(12'hB80, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h0) $display("FAIL mcycleh_written: got %h exp 0", rd_v); else pass_cnt++;
    tick();
    csr_read(12'hB80, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h1) $display("FAIL mcycle_carry_hi: got %h exp 1", rd_v); else pass_cnt++;
    csr_read(12'hB00, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h0) $display("FAIL mcycle_carry_lo: got %h exp 0", rd_v); else pass_cnt++;
    csr_write(2'b01, 12'hB00, 32'hFFFFFFFF);
    csr_write(2'b01, 12'hB80, 32'hFFFFFFFF);
    tick();
    csr_read(12'hB80, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h0) $display("FAIL mcycle_wrap: got %h exp 0", rd_v); else pass_cnt++;
    retire_i = 1'b1;
    csr_write(2'b01, 12'hB02, 32'h1234);
    retire_i = 1'b0;
    csr_read(12'hB02, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h1234) $display("FAIL minstret_write_wins: got %h exp 1234", rd_v); else pass_cnt++;
    retire_i = 1'b1; tick(); tick(); tick(); retire_i = 1'b0;
    csr_read(12'hB02, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h1237) $display("FAIL minstret_count: got %h exp 1237", rd_v); else pass_cnt++;
    tick(); tick();
    csr_read(12'hB02, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h1237) $display("FAIL minstret_idle_hold: got %h exp 1237", rd_v); else pass_cnt++;
    csr_write(2'b01, 12'hB02, 32'hFFFFFFFF);
    csr_write(2'b01, 12'hB82, 32'hFFFFFFFF);
    retire_i = 1'b1; tick(); retire_i = 1'b0;
    csr_read(12'hB82, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h0) $display("FAIL minstret_wrap: got %h exp 0", rd_v); else pass_cnt++;
  endtask

  task automatic test_reset_mid_trap();
    csr_write(2'b01, 12'h340, 32'hAAAA);
    is_ecall_i = 1'b1; pc_i = 32'h400;
    tick();
    is_ecall_i = 1'b0;
    rst = 1'b1;
    exp_q.push_back({3'b000, 32'h0});
    #1;
    exp_v = exp_q.pop_front();
    total_cnt++; if ({trap_taken_o, irq_taken_o, mret_taken_o} !== exp_v[34:32])
      $display("FAIL rst_mid_pulse: got %b exp %b", {trap_taken_o, irq_taken_o, mret_taken_o}, exp_v[34:32]); else pass_cnt++;
    tick();
    rst = 1'b0;
    csr_read(12'hB00, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h0) $display("FAIL rst_mid_mcycle: got %h exp 0", rd_v); else pass_cnt++;
    total_cnt++; if (trap_taken_o !== 1'b0) $display("FAIL rst_mid_no_pulse: got %b exp 0", trap_taken_o); else pass_cnt++;
    total_cnt++; if (trap_target_o !== 32'h0) $display("FAIL rst_mid_target: got %h exp 0", trap_target_o); else pass_cnt++;
    total_cnt++; if (mepc_o !== 32'h0) $display("FAIL rst_mid_mepc: got %h exp 0", mepc_o); else pass_cnt++;
    csr_read(12'h340, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h0) $display("FAIL rst_mid_mscratch: got %h exp 0", rd_v); else pass_cnt++;
    csr_read(12'h305, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h28) $display("FAIL rst_mid_mtvec: got %h exp 28", rd_v); else pass_cnt++;
    csr_read(12'h300, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h1800) $display("FAIL rst_mid_mstatus: got %h exp 1800", rd_v); else pass_cnt++;
    csr_read(12'h342, rd_v, ill_v);
    total_cnt++; if (rd_v !== 32'h0) $display("FAIL rst_mid_mcause: got %h exp 0", rd_v); else pass_cnt++;
    tick();
  endtask

  initial begin
    rst = 1'b1; pc_i = 32'h0; clear_inputs();
    test_reset();
    test_irq_vectored();
    test_ecall_mret();
    test_priority();
    test_csr_ops();
    test_counters();
    test_reset_mid_trap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
